segment_scan: RTL

Parametrised multiplexed 7-segment display driver, successor to the fixed 8-digit segment block. A bus-mapped register bank holds one raw segment byte per digit, a per-digit blink mask and a control word. A scan engine time-multiplexes the digits onto a shared segment bus, with guard-band blanking between slots. Sits on the system slave bus between the CPU and the board's common-anode display pins.

---
 rtl/segment_scan_if.sv | 20 ++
 rtl/segment_scan.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/segment_scan_if.sv
// Slave bus bundle for segment_scan: word-addressed register access with
// byte-lane write enables and a registered read response.
interface segment_scan_if;
  logic [2:0]  slave_address;
  logic        slave_write;
  logic [31:0] slave_writedata;
  logic [3:0]  slave_byteenable;
  logic        slave_read;
  logic [31:0] slave_readdata;

  modport master (
    output slave_address, slave_write, slave_writedata, slave_byteenable, slave_read,
    input  slave_readdata
  );

  modport slave (
    input  slave_address, slave_write, slave_writedata, slave_byteenable, slave_read,
    output slave_readdata
  );
endinterface

// File: rtl/segment_scan.sv
// Multiplexed 7-segment driver: register bank (digit bytes, blink mask, control)
// plus a scan engine with guard-band blanking. Optional hex decoder: SEGMENT_HEXDECODE_EN.
module segment_scan #(
  parameter int DIGITS    = 8,
  parameter int SCAN_DIV  = 17,
  parameter int GUARD     = 4,
  parameter int BLINK_DIV = 26
) (
  input  logic              clk,
  input  logic              reset_n,
  segment_scan_if.slave     bus,
  output logic [DIGITS-1:0] en,
  output logic [7:0]        seg_data
);
  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [2:0] ADDR_BLINK  = 3'd4;
  localparam logic [2:0] ADDR_CTRL   = 3'd5;
  localparam logic [2:0] ADDR_STATUS = 3'd6;

  logic [8*DIGITS-1:0] digit_flat;
  logic [DIGITS-1:0]   blink_vec;
  logic                disp_en_reg;
  logic                hex_mode;
  logic [SCAN_DIV-1:0] pos_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic [BLINK_DIV:0]  blink_cnt_reg;
  logic [31:0]         readdata_reg, readdata_next;
  logic [DIGITS-1:0]   en_reg, en_next;
  logic [7:0]          seg_reg, seg_next;
  logic [127:0]        digit_pad;
  logic [7:0]          cur_byte, shown_byte;
  logic                shown;

  // Each digit owns its byte and blink bit, so byte lanes map without muxing.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      localparam logic [2:0] WORD = 3'(gi / 4);
      logic [7:0] byte_reg;
      logic       blink_bit_reg;

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          byte_reg      <= '0;
          blink_bit_reg <= 1'b0;
        end else if (bus.slave_write) begin
          if (bus.slave_address == WORD && bus.slave_byteenable[gi % 4])
            byte_reg <= bus.slave_writedata[8*(gi % 4) +: 8];
          if (bus.slave_address == ADDR_BLINK && bus.slave_byteenable[gi / 8])
            blink_bit_reg <= bus.slave_writedata[gi];
        end
      end

      assign digit_flat[8*gi +: 8] = byte_reg;
      assign blink_vec[gi]         = blink_bit_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_n)
      disp_en_reg <= 1'b1;
    else if (bus.slave_write && bus.slave_address == ADDR_CTRL && bus.slave_byteenable[0])
      disp_en_reg <= bus.slave_writedata[0];
  end

`ifdef SEGMENT_HEXDECODE_EN
  logic hex_mode_reg;

  always_ff @(posedge clk) begin
    if (!reset_n)
      hex_mode_reg <= 1'b0;
    else if (bus.slave_write && bus.slave_address == ADDR_CTRL && bus.slave_byteenable[0])
      hex_mode_reg <= bus.slave_writedata[1];
  end

  assign hex_mode = hex_mode_reg;

  // Segments g..a in bits 6:0, active-high.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F; 4'h1: hex7 = 7'h06; 4'h2: hex7 = 7'h5B; 4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66; 4'h5: hex7 = 7'h6D; 4'h6: hex7 = 7'h7D; 4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F; 4'h9: hex7 = 7'h6F; 4'hA: hex7 = 7'h77; 4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39; 4'hD: hex7 = 7'h5E; 4'hE: hex7 = 7'h79; default: hex7 = 7'h71;
    endcase
  endfunction
`else
  assign hex_mode = 1'b0;
`endif

  // Digit index wraps explicitly so non-power-of-two digit counts (12) scan correctly.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pos_reg       <= '0;
      idx_reg       <= '0;
      blink_cnt_reg <= '0;
    end else begin
      pos_reg       <= pos_reg + 1'b1;
      blink_cnt_reg <= blink_cnt_reg + 1'b1;
      if (&pos_reg)
        idx_reg <= (idx_reg == IDX_W'(DIGITS - 1)) ? '0 : idx_reg + 1'b1;
    end
  end

  assign digit_pad = 128'(digit_flat);

  always_comb begin
    readdata_next = '0;
    case (bus.slave_address)
      3'd0, 3'd1, 3'd2, 3'd3: readdata_next = digit_pad[{bus.slave_address[1:0], 5'b0} +: 32];
      ADDR_BLINK:             readdata_next = 32'(blink_vec);
      ADDR_CTRL:              readdata_next = {30'b0, hex_mode, disp_en_reg};
      ADDR_STATUS:            readdata_next = {27'b0, blink_cnt_reg[BLINK_DIV], 4'(idx_reg)};
      default:                readdata_next = '0;
    endcase
  end

  always_comb begin
    cur_byte   = digit_flat[{idx_reg, 3'b000} +: 8];
    shown_byte = cur_byte;
`ifdef SEGMENT_HEXDECODE_EN
    if (hex_mode)
      shown_byte = {cur_byte[4], hex7(cur_byte[3:0])};
`endif
    shown = disp_en_reg && (pos_reg >= SCAN_DIV'(GUARD)) &&
            (!blink_vec[idx_reg] || blink_cnt_reg[BLINK_DIV]);
    en_next  = '1;
    seg_next = '0;
    if (shown) begin
      en_next  = ~({1'b1, {(DIGITS-1){1'b0}}} >> idx_reg);
      seg_next = shown_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      en_reg       <= '1;
      seg_reg      <= '0;
      readdata_reg <= '0;
    end else begin
      en_reg  <= en_next;
      seg_reg <= seg_next;
      if (bus.slave_read)
        readdata_reg <= readdata_next;
    end
  end

  assign en                 = en_reg;
  assign seg_data           = seg_reg;
  assign bus.slave_readdata = readdata_reg;
endmodule
